cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Shares the single common data bus (CDB) between the two result producers: the RS/ALU and the LSB.
//  Each producer writes results into its own FIFO. A round-robin arbiter then issues at most one
//  registered broadcast per cycle. That broadcast (RoB index + value) is consumed by the RoB, RS, LSB and dispatcher.
//  On a RoB mispredict flush, the block drops all buffered (speculative) results.
// PARAMETERS
//  RoB_WIDTH   8  width of a RoB index
//  FIFO_DEPTH  4  entries per producer FIFO; must be a power of 2, >= 2
//  FIFO_AW     2  log2(FIFO_DEPTH); pointer width
// PORTS
//  clk              in   1          system clock, rising edge
//  rst              in   1          asynchronous, active-low reset (0 = reset)
//  rdy              in   1          global enable; 0 = freeze all state
//  RSCDB_en         in   1          RS/ALU result valid this cycle
//  RSCDB_RoB_index  in   RoB_WIDTH  RoB entry of the RS result
//  RSCDB_value      in   32         RS result value
//  CDBRS_full       out  1          RS FIFO full; RS must not assert RSCDB_en
//  LSBCDB_en        in   1          LSB result valid this cycle
//  LSBCDB_RoB_index in   RoB_WIDTH  RoB entry of the LSB result
//  LSBCDB_value     in   32         LSB load value (stores report 0)
//  CDBLSB_full      out  1          LSB FIFO full; LSB must not assert LSBCDB_en
//  RoBCDB_flush     in   1          1 = mispredict, discard everything buffered
//  CDB_en           out  1          broadcast valid
//  CDB_RoB_index    out  RoB_WIDTH  broadcast RoB index
//  CDB_value        out  32         broadcast value
//  CDB_src          out  1          0 = from RS, 1 = from LSB
//  CDB_overflow     out  1          sticky: a push arrived while its FIFO was full
// BEHAVIOUR
//  Reset (rst=0, async): all outputs 0; FIFOs empty with pointers/counts 0; last_grant=1 (RS wins first tie).
//  Priority per rising edge: flush > !rdy > normal.
//  Flush (RoBCDB_flush=1, applied even when rdy=0):
//   - both FIFOs emptied; CDB_en<=0; same-cycle pushes dropped
//   - last_grant and CDB_overflow keep their values
//  rdy=0 (no flush): every register holds, including CDB_* outputs; pushes are ignored.
//  Push: xx_en && !full -> write {index,value} at wr_ptr; wr_ptr+1 wraps mod FIFO_DEPTH.
//   Push while full -> entry dropped and CDB_overflow<=1 (stays 1 until reset).
//  full = (count == FIFO_DEPTH). It is computed from registered count only, so a pop in the same cycle
//   does not make room for a push in that cycle.
//  Arbitration (uses FIFO state at the start of the cycle):
//   - both non-empty -> grant the source != last_grant
//   - one non-empty -> grant that one
//   - none -> no grant
//  Grant -> pop the head of the granted FIFO; CDB_en<=1; CDB_RoB_index/value<=head;
//   CDB_src<=granted source; last_grant<=granted source.
//   No grant -> CDB_en<=0; index/value/src hold their last values.
//  Latency: a result pushed at edge t is broadcast at the earliest at edge t+1, i.e. visible in cycle t+1..t+2.
//   No bypass from producer inputs to the CDB.
//  Each CDB_en=1 cycle is exactly one broadcast. Consumers gate it with rdy.
//  Throughput: 1 broadcast/cycle. Under sustained contention, RS and LSB strictly alternate.
//  Ordering: FIFO order is preserved per source. No ordering between sources is guaranteed or needed,
//   because RoB commits in order.
//  Simultaneous push and pop on the same FIFO: count unchanged; the pointers advance independently.
//  Implementation: count is FIFO_AW+1 bits wide.
// TESTING
//  1 Reset:
//   rst=0 mid-traffic, asynchronously -> outputs 0 immediately; after release the first RS/LSB tie grants RS.
//  2 Single source:
//   RS pushes idx 5/val 0x11, then idx 6/val 0x22 on back-to-back edges ->
//   CDB shows (5,0x11,src0) then (6,0x22,src0) on consecutive cycles; CDB_en then drops to 0.
//  3 Contention:
//   RS and LSB each hold 3 entries -> 6 consecutive broadcasts alternating src 0,1,0,1,0,1.
//  4 Full/overflow:
//   4 RS pushes with no pops (LSB kept busy by an always-full LSB stream) -> CDBRS_full=1;
//   a 5th push is dropped and CDB_overflow=1.
//  5 Flush:
//   2 entries per FIFO, then RoBCDB_flush=1 for one cycle with a push in the same cycle ->
//   next cycle CDB_en=0, both FIFOs empty, full flags 0.
//  6 Stall:
//   rdy=0 for 3 cycles while CDB_en=1 with (9,0x33) -> outputs hold at (9,0x33) and pushes are ignored;
//   after rdy=1, arbitration resumes in FIFO order.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: producer result ports, flush and the common data bus broadcast
interface cdb_arbiter_if #(
  parameter int RoB_WIDTH = 8
);
  logic                 RSCDB_en;
  logic [RoB_WIDTH-1:0] RSCDB_RoB_index;
  logic [31:0]          RSCDB_value;
  logic                 CDBRS_full;
  logic                 LSBCDB_en;
  logic [RoB_WIDTH-1:0] LSBCDB_RoB_index;
  logic [31:0]          LSBCDB_value;
  logic                 CDBLSB_full;
  logic                 RoBCDB_flush;
  logic                 CDB_en;
  logic [RoB_WIDTH-1:0] CDB_RoB_index;
  logic [31:0]          CDB_value;
  logic                 CDB_src;
  logic                 CDB_overflow;
  modport master (
    output RSCDB_en, RSCDB_RoB_index, RSCDB_value,
    output LSBCDB_en, LSBCDB_RoB_index, LSBCDB_value,
    output RoBCDB_flush,
    input  CDBRS_full, CDBLSB_full,
    input  CDB_en, CDB_RoB_index, CDB_value, CDB_src, CDB_overflow
  );
  modport slave (
    input  RSCDB_en, RSCDB_RoB_index, RSCDB_value,
    input  LSBCDB_en, LSBCDB_RoB_index, LSBCDB_value,
    input  RoBCDB_flush,
    output CDBRS_full, CDBLSB_full,
    output CDB_en, CDB_RoB_index, CDB_value, CDB_src, CDB_overflow
  );
endinterface

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: per-producer result FIFOs round-robin arbitrated onto one registered common data bus
module cdb_arbiter #(
  parameter int RoB_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input logic          clk,
  input logic          rst_n,
  input logic          rdy,
  cdb_arbiter_if.slave bus
);
  localparam int EW = RoB_WIDTH + 32;
  localparam logic [FIFO_AW:0] DEPTH = (FIFO_AW+1)'(FIFO_DEPTH);
  logic [EW-1:0]        mem [2][FIFO_DEPTH];
  logic [EW-1:0]        din [2];
  logic [FIFO_AW-1:0]   wr_ptr [2];
  logic [FIFO_AW-1:0]   rd_ptr [2];
  logic [FIFO_AW:0]     cnt [2];
  logic [1:0]           en_in, full, busy, push, pop;
  logic                 last_grant, gnt, gnt_src;
  logic                 cdb_en, cdb_src, overflow;
  logic [RoB_WIDTH-1:0] cdb_idx;
  logic [31:0]          cdb_val;
  assign en_in  = {bus.LSBCDB_en, bus.RSCDB_en};
  assign din[0] = {bus.RSCDB_RoB_index, bus.RSCDB_value};
  assign din[1] = {bus.LSBCDB_RoB_index, bus.LSBCDB_value};
  for (genvar s = 0; s < 2; s++) begin : g_src
    assign full[s] = cnt[s] == DEPTH;
    assign busy[s] = cnt[s] != '0;
  end
  // full comes from the registered count, so a same-cycle pop never frees room for a push
  assign push    = en_in & ~full;
  assign gnt     = |busy;
  assign gnt_src = &busy ? ~last_grant : busy[1];
  assign pop     = gnt ? (gnt_src ? 2'b10 : 2'b01) : 2'b00;
  always_ff @(posedge clk) begin
    if (rdy && !bus.RoBCDB_flush)
      for (int s = 0; s < 2; s++)
        if (push[s]) mem[s][wr_ptr[s]] <= din[s];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      last_grant <= 1'b1;
      overflow   <= 1'b0;
      cdb_en     <= 1'b0;
      cdb_src    <= 1'b0;
      cdb_idx    <= '0;
      cdb_val    <= '0;
    end else if (bus.RoBCDB_flush) begin
      for (int s = 0; s < 2; s++) begin
        wr_ptr[s] <= '0;
        rd_ptr[s] <= '0;
        cnt[s]    <= '0;
      end
      cdb_en <= 1'b0;
    end else if (rdy) begin
      for (int s = 0; s < 2; s++) begin
        if (push[s]) wr_ptr[s] <= wr_ptr[s] + 1'b1;
        if (pop[s]) rd_ptr[s] <= rd_ptr[s] + 1'b1;
        cnt[s] <= cnt[s] + (FIFO_AW+1)'(push[s]) - (FIFO_AW+1)'(pop[s]);
      end
      if (|(en_in & full)) overflow <= 1'b1;
      cdb_en <= gnt;
      if (gnt) begin
        {cdb_idx, cdb_val} <= mem[gnt_src][rd_ptr[gnt_src]];
        cdb_src            <= gnt_src;
        last_grant         <= gnt_src;
      end
    end
  end
  assign bus.CDBRS_full    = full[0];
  assign bus.CDBLSB_full   = full[1];
  assign bus.CDB_en        = cdb_en;
  assign bus.CDB_RoB_index = cdb_idx;
  assign bus.CDB_value     = cdb_val;
  assign bus.CDB_src       = cdb_src;
  assign bus.CDB_overflow  = overflow;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: table vectors plus per-source scoreboard checking every consumed CDB broadcast
module tb_cdb_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, rdy = 1'b0;
  int checks = 0, passed = 0;
  logic [39:0] rs_q[$], lsb_q[$];
  logic [39:0] mon_e;
  typedef struct {
    logic re; logic [7:0] ri; logic [31:0] rv;
    logic le; logic [7:0] li; logic [31:0] lv;
    logic ee; logic es;
  } vec_t;
  vec_t tbl[12];
  cdb_arbiter_if #(.RoB_WIDTH(8)) bus();
  cdb_arbiter #(.RoB_WIDTH(8), .FIFO_DEPTH(4), .FIFO_AW(2)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // a broadcast is consumed in each cycle where CDB_en and rdy are both high
  always @(negedge clk) begin
    if (rst_n && rdy && bus.CDB_en) begin
      if (bus.CDB_src ? lsb_q.size() == 0 : rs_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_bcast: got src %0d idx %0h val %0h, expected no broadcast",
                 bus.CDB_src, bus.CDB_RoB_index, bus.CDB_value);
      end else begin
        if (bus.CDB_src) mon_e = lsb_q.pop_front();
        else mon_e = rs_q.pop_front();
        check(bus.CDB_src ? "bcast_lsb" : "bcast_rs", {bus.CDB_RoB_index, bus.CDB_value}, mon_e);
      end
    end
  end

  task automatic cyc(input logic re, input logic [7:0] ri, input logic [31:0] rv,
                     input logic le, input logic [7:0] li, input logic [31:0] lv,
                     input logic fl, input logic acc_r, input logic acc_l);
    bus.RSCDB_en = re; bus.RSCDB_RoB_index = ri; bus.RSCDB_value = rv;
    bus.LSBCDB_en = le; bus.LSBCDB_RoB_index = li; bus.LSBCDB_value = lv;
    bus.RoBCDB_flush = fl;
    if (acc_r) rs_q.push_back({ri, rv});
    if (acc_l) lsb_q.push_back({li, lv});
    @(posedge clk); #1;
    if (fl) begin rs_q.delete(); lsb_q.delete(); end
    bus.RSCDB_en = 1'b0; bus.LSBCDB_en = 1'b0; bus.RoBCDB_flush = 1'b0;
  endtask

  task automatic idle();
    cyc(0, 8'h0, 32'h0, 0, 8'h0, 32'h0, 0, 0, 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((rs_q.size() + lsb_q.size() != 0 || bus.CDB_en) && n < 40) begin
      idle();
      n++;
    end
    check(name, {bus.CDB_en, 32'(rs_q.size() + lsb_q.size())}, 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1);
  end

  initial begin
    bus.RSCDB_en = 0; bus.RSCDB_RoB_index = 0; bus.RSCDB_value = 0;
    bus.LSBCDB_en = 0; bus.LSBCDB_RoB_index = 0; bus.LSBCDB_value = 0;
    bus.RoBCDB_flush = 0;
    tbl[0]  = '{1'b1, 8'h10, 32'hA0, 1'b1, 8'h20, 32'hB0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'h11, 32'hA1, 1'b1, 8'h21, 32'hB1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 8'h12, 32'hA2, 1'b1, 8'h22, 32'hB2, 1'b1, 1'b1};
    tbl[3]  = '{1'b0, 8'h00, 32'h00, 1'b0, 8'h00, 32'h00, 1'b1, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 32'h00, 1'b0, 8'h00, 32'h00, 1'b1, 1'b1};
    tbl[5]  = '{1'b0, 8'h00, 32'h00, 1'b0, 8'h00, 32'h00, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 32'h00, 1'b0, 8'h00, 32'h00, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 32'h00, 1'b0, 8'h00, 32'h00, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h05, 32'h11, 1'b0, 8'h00, 32'h00, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'h06, 32'h22, 1'b0, 8'h00, 32'h00, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 32'h00, 1'b0, 8'h00, 32'h00, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 32'h00, 1'b0, 8'h00, 32'h00, 1'b0, 1'b0};
    #12;
    check("reset_state", {bus.CDB_en, bus.CDB_RoB_index, bus.CDB_value, bus.CDB_src,
                          bus.CDB_overflow, bus.CDBRS_full, bus.CDBLSB_full}, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy   = 1'b1;
    // RS pushes every cycle, LSB every other cycle: RS fills at edge 7, edge 8 push is dropped
    for (int k = 1; k <= 8; k++) begin
      cyc(1, 8'(8'h40 + k), 32'h400 + k, k[0], 8'(8'h50 + k), 32'h500 + k, 0, k < 8, k[0]);
      check("rs_full", bus.CDBRS_full, k == 7);
      check("lsb_full", bus.CDBLSB_full, 0);
      check("overflow", bus.CDB_overflow, k == 8);
    end
    drain("drain_full");
    cyc(1, 8'h60, 32'h600, 1, 8'h70, 32'h700, 0, 1, 1);
    cyc(1, 8'h61, 32'h601, 1, 8'h71, 32'h701, 0, 1, 1);
    cyc(1, 8'h62, 32'h602, 1, 8'h72, 32'h702, 1, 0, 0);
    check("flush_en", bus.CDB_en, 0);
    check("flush_full", {bus.CDBRS_full, bus.CDBLSB_full}, 0);
    check("flush_keeps_ovf", bus.CDB_overflow, 1);
    idle();
    check("flush_idle_en", bus.CDB_en, 0);
    cyc(1, 8'h63, 32'h603, 0, 8'h0, 32'h0, 0, 1, 0);
    drain("drain_flush");
    cyc(1, 8'h09, 32'h33, 0, 8'h0, 32'h0, 0, 1, 0);
    cyc(1, 8'h0A, 32'h44, 0, 8'h0, 32'h0, 0, 1, 0);
    check("stall_pre", {bus.CDB_en, bus.CDB_RoB_index, bus.CDB_value}, {1'b1, 8'h09, 32'h33});
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc(1, 8'h77, 32'h777, 1, 8'h78, 32'h778, 0, 0, 0);
      check("stall_hold", {bus.CDB_en, bus.CDB_RoB_index, bus.CDB_value, bus.CDB_src},
            {1'b1, 8'h09, 32'h33, 1'b0});
    end
    rdy = 1'b1;
    drain("drain_stall");
    cyc(1, 8'h80, 32'h800, 1, 8'h90, 32'h900, 0, 1, 1);
    cyc(1, 8'h81, 32'h801, 1, 8'h91, 32'h901, 0, 1, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {bus.CDB_en, bus.CDB_RoB_index, bus.CDB_value, bus.CDB_src,
                          bus.CDB_overflow, bus.CDBRS_full, bus.CDBLSB_full}, 64'd0);
    rs_q.delete();
    lsb_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].re, tbl[i].ri, tbl[i].rv, tbl[i].le, tbl[i].li, tbl[i].lv, 0, tbl[i].re, tbl[i].le);
      check("tbl_en", bus.CDB_en, tbl[i].ee);
      if (tbl[i].ee) check("tbl_src", bus.CDB_src, tbl[i].es);
    end
    drain("drain_tbl");
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
